shot_link_ctl: RTL

Link scheduler for the two-board battleship game. Sits between the game state machine and the UART byte interface and shares the single TX channel between two requesters: our shot (target address) and our hit/miss reply to the opponent's shot. Decodes incoming frames into opponent-shot and shot-result events, tracks the one outstanding shot and flags a lost reply by timeout.

---
 rtl/shot_link_if.sv | 30 +++
 rtl/shot_link_ctl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/shot_link_if.sv
// shot_link_if: game-side request/result signals plus the UART byte channels of the link scheduler
interface shot_link_if;
  logic       shot_req;
  logic [7:0] shot_addr;
  logic       shot_ack;
  logic       reply_req;
  logic       reply_hit;
  logic       reply_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_shot_valid;
  logic [7:0] rx_shot_addr;
  logic       result_valid;
  logic       result_hit;
  logic       busy;
  logic       timeout;
  modport master (
    output shot_req, shot_addr, reply_req, reply_hit, tx_ready, rx_data, rx_valid,
    input  shot_ack, reply_ack, tx_data, tx_valid, rx_shot_valid, rx_shot_addr,
           result_valid, result_hit, busy, timeout
  );
  modport slave (
    input  shot_req, shot_addr, reply_req, reply_hit, tx_ready, rx_data, rx_valid,
    output shot_ack, reply_ack, tx_data, tx_valid, rx_shot_valid, rx_shot_addr,
           result_valid, result_hit, busy, timeout
  );
endinterface

// File: rtl/shot_link_ctl.sv
// shot_link_ctl: shares UART TX between shot and reply frames, decodes RX frames, times out our shot (LINK_RETRY_EN enables resends)
module shot_link_ctl #(
  parameter int TIMEOUT_CYCLES = 6_500_000,
  parameter int RETRY_MAX      = 3
) (
  input logic        clk,
  input logic        rst,
  shot_link_if.slave bus
);
`ifdef LINK_RETRY_EN
  localparam int RETRIES = RETRY_MAX;
`else
  localparam int RETRIES = 0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HDR_SHOT  = 8'hA5;
  localparam logic [7:0] HDR_REPLY = 8'h5A;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SHOT, RX_REPLY} rx_st_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_SHOT, SRC_REPLY, SRC_RESEND} src_t;
  tx_st_t        r_tx_st, w_tx_nxt;
  src_t          r_src, w_src_nxt;
  logic          r_tx_valid, w_txv_nxt;
  logic [7:0]    r_tx_data, w_txd_nxt;
  logic [7:0]    r_addr;
  logic          r_hit;
  rx_st_t        r_rx_st, w_rx_nxt;
  logic          r_rx_shot_valid, r_result_valid, r_result_hit, r_busy, r_timeout;
  logic [7:0]    r_rx_shot_addr;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_pend;
  logic          w_pay_done, w_shot_done, w_resend_done, w_rx_shot, w_res_ok, w_expire, w_give_up;
  assign w_pay_done    = r_tx_st == TX_PAY && bus.tx_ready;
  assign w_shot_done   = w_pay_done && r_src == SRC_SHOT;
  assign w_resend_done = w_pay_done && r_src == SRC_RESEND;
  assign w_rx_shot     = r_rx_st == RX_SHOT && bus.rx_valid;
  assign w_res_ok      = r_rx_st == RX_REPLY && bus.rx_valid && r_busy && bus.rx_data[7:1] == 7'd0;
  // counter is frozen while a resend is queued or in flight; a reply landing on expiry wins
  assign w_expire      = r_busy && !r_pend && r_cnt == CNT_LAST && !w_res_ok;
  assign w_give_up     = w_expire && r_retry == RW'(RETRIES);
  // TX next state: reply first, then a queued resend, then a fresh shot when none is outstanding
  always_comb begin
    w_tx_nxt  = r_tx_st;
    w_src_nxt = r_src;
    w_txv_nxt = r_tx_valid;
    w_txd_nxt = r_tx_data;
    case (r_tx_st)
      TX_IDLE: begin
        w_src_nxt = bus.reply_req ? SRC_REPLY : r_pend ? SRC_RESEND :
                    (bus.shot_req && !r_busy) ? SRC_SHOT : SRC_NONE;
        w_tx_nxt  = (w_src_nxt == SRC_NONE) ? TX_IDLE : TX_HDR;
        w_txv_nxt = w_src_nxt != SRC_NONE;
        w_txd_nxt = (w_src_nxt == SRC_NONE) ? 8'h00 : (w_src_nxt == SRC_REPLY) ? HDR_REPLY : HDR_SHOT;
      end
      TX_HDR: if (bus.tx_ready) begin
        w_tx_nxt  = TX_PAY;
        w_txd_nxt = (r_src == SRC_REPLY) ? {7'd0, r_hit} : r_addr;
      end
      TX_PAY: if (bus.tx_ready) begin
        w_tx_nxt  = TX_IDLE;
        w_src_nxt = SRC_NONE;
        w_txv_nxt = 1'b0;
        w_txd_nxt = 8'h00;
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end
  // TX state, registered byte output and the payload latched when a source is selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st    <= TX_IDLE;
      r_src      <= SRC_NONE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_addr     <= 8'h00;
      r_hit      <= 1'b0;
    end else begin
      r_tx_st    <= w_tx_nxt;
      r_src      <= w_src_nxt;
      r_tx_valid <= w_txv_nxt;
      r_tx_data  <= w_txd_nxt;
      if (r_tx_st == TX_IDLE && w_src_nxt == SRC_SHOT) r_addr <= bus.shot_addr;
      if (r_tx_st == TX_IDLE && w_src_nxt == SRC_REPLY) r_hit <= bus.reply_hit;
    end
  end
  // RX next state: header selects frame type, the following byte is always payload
  always_comb begin
    w_rx_nxt = r_rx_st;
    if (bus.rx_valid)
      w_rx_nxt = (r_rx_st != RX_IDLE) ? RX_IDLE : (bus.rx_data == HDR_SHOT) ? RX_SHOT :
                 (bus.rx_data == HDR_REPLY) ? RX_REPLY : RX_IDLE;
  end
  // RX state and the registered event strobes with their held values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st         <= RX_IDLE;
      r_rx_shot_valid <= 1'b0;
      r_rx_shot_addr  <= 8'h00;
      r_result_valid  <= 1'b0;
      r_result_hit    <= 1'b0;
    end else begin
      r_rx_st         <= w_rx_nxt;
      r_rx_shot_valid <= w_rx_shot;
      r_result_valid  <= w_res_ok;
      if (w_rx_shot) r_rx_shot_addr <= bus.rx_data;
      if (w_res_ok) r_result_hit <= bus.rx_data[0];
    end
  end
  // outstanding-shot tracking: busy flag, reply timer, resend queue and retry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_busy    <= w_shot_done ? 1'b1 : (w_res_ok || w_give_up) ? 1'b0 : r_busy;
      r_timeout <= w_give_up;
      r_cnt     <= (!r_busy || r_pend || w_expire || w_res_ok) ? '0 : r_cnt + 1'b1;
      r_retry   <= w_shot_done ? '0 : (w_expire && !w_give_up) ? r_retry + 1'b1 : r_retry;
      r_pend    <= (w_res_ok || w_resend_done) ? 1'b0 : (w_expire && !w_give_up) ? 1'b1 : r_pend;
    end
  end
  assign bus.shot_ack      = w_shot_done;
  assign bus.reply_ack     = w_pay_done && r_src == SRC_REPLY;
  assign bus.tx_valid      = r_tx_valid;
  assign bus.tx_data       = r_tx_data;
  assign bus.rx_shot_valid = r_rx_shot_valid;
  assign bus.rx_shot_addr  = r_rx_shot_addr;
  assign bus.result_valid  = r_result_valid;
  assign bus.result_hit    = r_result_hit;
  assign bus.busy          = r_busy;
  assign bus.timeout       = r_timeout;
endmodule
